// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared sample width, frame size, serializer state and sample type
package dsp_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int FRAME_BITS   = 2 * DEF_SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } ser_state_t;

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - pointer-based first-word-fall-through sample buffer
module sample_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sample_serializer.sv
// rtl/sample_serializer.sv - buffers filtered samples and serializes them onto a left-justified stereo DAC link
module sample_serializer #(
    parameter int SAMPLE_W   = dsp_pkg::DEF_SAMPLE_W,
    parameter int BCLK_DIV   = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                clr_flags,
    output logic                dac_bclk,
    output logic                dac_lrclk,
    output logic                dac_sdata,
    output logic                busy,
    output logic                overrun,
    output logic                underrun
);
    import dsp_pkg::*;

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(BCLK_DIV + 1);

    ser_state_t          state;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    next_bit;
    logic [BIT_W-2:0]    sel;
    logic [SAMPLE_W-1:0] frame_reg;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                tc, fall, wrap, cont, start, drop, starve;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .sys_clk (sys_clk),
        .reset   (reset),
        .push    (sample_valid),
        .pop     (fifo_pop),
        .din     (sample_in),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        tc       = (div_cnt == DIV_W'(BCLK_DIV - 1));
        fall     = (state != IDLE) && tc && dac_bclk;
        wrap     = fall && (bit_cnt == BIT_W'(FRAME_W - 1));
        next_bit = wrap ? '0 : bit_cnt + BIT_W'(1);
        sel      = (BIT_W-1)'(SAMPLE_W - 1) - next_bit[BIT_W-2:0];
        // DRAIN with en back high behaves exactly like RUN at the frame boundary.
        cont     = (state == RUN) || ((state == DRAIN) && en);
        start    = (state == IDLE) && en && !fifo_empty;
        fifo_pop = start || (wrap && cont && !fifo_empty);
        starve   = wrap && cont && fifo_empty;
        drop     = sample_valid && fifo_full && !fifo_pop;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            frame_reg <= '0;
            dac_bclk  <= 1'b0;
            dac_lrclk <= 1'b0;
            dac_sdata <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dac_bclk  <= 1'b0;
                    dac_lrclk <= 1'b0;
                    dac_sdata <= 1'b0;
                    if (start) begin
                        frame_reg <= fifo_dout;
                        dac_sdata <= fifo_dout[SAMPLE_W-1];
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        state     <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if ((state == RUN) && !en)        state <= DRAIN;
                    else if ((state == DRAIN) && en)  state <= RUN;
                    if (tc) begin
                        div_cnt  <= '0;
                        dac_bclk <= ~dac_bclk;
                        // Data and word select change with the falling bclk toggle.
                        if (dac_bclk) begin
                            bit_cnt   <= next_bit;
                            dac_lrclk <= next_bit[BIT_W-1];
                            dac_sdata <= frame_reg[sel];
                            if (wrap) begin
                                if (!cont) begin
                                    state     <= IDLE;
                                    dac_lrclk <= 1'b0;
                                    dac_sdata <= 1'b0;
                                end else if (!fifo_empty) begin
                                    frame_reg <= fifo_dout;
                                    dac_sdata <= fifo_dout[SAMPLE_W-1];
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= (overrun  && !clr_flags) || drop;
            underrun <= (underrun && !clr_flags) || starve;
        end
    end

endmodule

// File: tb/tb_sample_serializer.sv
// tb/tb_sample_serializer.sv - scoreboard bench for sample_serializer
module tb_sample_serializer;
    import dsp_pkg::*;

    logic    sys_clk = 1'b0;
    logic    reset = 1'b1;
    logic    en = 1'b0;
    logic    sample_valid = 1'b0;
    logic    clr_flags = 1'b0;
    sample_t sample_in = '0;
    logic    dac_bclk, dac_lrclk, dac_sdata, busy, overrun, underrun;

    int      tests = 0;
    int      fails = 0;
    sample_t exp_q[$];

    sample_serializer dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clr_flags    (clr_flags),
        .dac_bclk     (dac_bclk),
        .dac_lrclk    (dac_lrclk),
        .dac_sdata    (dac_sdata),
        .busy         (busy),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: collect 32 bits on each frame (sampled at bclk rising edges) and compare.
    logic        prev_bclk = 1'b0;
    int          nbits = 0;
    logic [31:0] word = '0;
    logic [31:0] lrw = '0;
    int          cyc = 0;
    int          start_cyc = 0;
    bit          have_prev = 1'b0;
    sample_t     s;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (!busy) begin
            nbits     = 0;
            have_prev = 1'b0;
        end else if (dac_bclk && !prev_bclk) begin
            if (nbits == 0) begin
                if (have_prev) check("frame_len", 32'(cyc - start_cyc), 32'd768);
                start_cyc = cyc;
                have_prev = 1'b1;
            end
            word = {word[30:0], dac_sdata};
            lrw  = {lrw[30:0], dac_lrclk};
            nbits++;
            if (nbits == FRAME_BITS) begin
                nbits = 0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got %h expected none", word);
                end else begin
                    s = exp_q.pop_front();
                    check("frame_data", word, {s, s});
                    check("frame_lrclk", lrw, 32'h0000ffff);
                end
            end
        end
        prev_bclk = dac_bclk;
    end

    task automatic push(input logic [15:0] v);
        @(posedge sys_clk); #1;
        sample_in    = v;
        sample_valid = 1'b1;
        @(posedge sys_clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic set_en(input logic v);
        @(posedge sys_clk); #1;
        en = v;
    endtask

    task automatic pulse_clr();
        @(posedge sys_clk); #1 clr_flags = 1'b1;
        @(posedge sys_clk); #1 clr_flags = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_bclk", {31'd0, dac_bclk}, 0);
        check("rst_lrclk", {31'd0, dac_lrclk}, 0);
        check("rst_sdata", {31'd0, dac_sdata}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_underrun", {31'd0, underrun}, 0);
        reset = 1'b1;

        // Basic frame, drained right after start
        exp_q.push_back(16'hA5C3);
        push(16'hA5C3);
        set_en(1'b1);
        repeat (20) @(posedge sys_clk);
        set_en(1'b0);
        wait_idle("basic_idle");
        check("basic_bclk", {31'd0, dac_bclk}, 0);
        check("basic_flags", {30'd0, overrun, underrun}, 0);

        // Steady rate: one push per frame period
        for (int v = 1; v <= 5; v++) exp_q.push_back(sample_t'(v));
        push(16'd1);
        set_en(1'b1);
        for (int v = 2; v <= 5; v++) begin
            push(16'(v));
            repeat (766) @(posedge sys_clk);
        end
        repeat (50) @(posedge sys_clk);
        set_en(1'b0);
        wait_idle("steady_idle");
        check("steady_flags", {30'd0, overrun, underrun}, 0);

        // Overrun: three back-to-back pushes into a depth-2 FIFO while idle
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        @(posedge sys_clk); #1;
        sample_valid = 1'b1;
        sample_in    = 16'h1111;
        @(posedge sys_clk); #1 sample_in = 16'h2222;
        @(posedge sys_clk); #1 sample_in = 16'h3333;
        @(posedge sys_clk); #1 sample_valid = 1'b0;
        check("ovr_set", {31'd0, overrun}, 1);
        set_en(1'b1);
        repeat (800) @(posedge sys_clk);
        set_en(1'b0);
        wait_idle("ovr_idle");
        check("ovr_no_underrun", {31'd0, underrun}, 0);
        pulse_clr();
        check("ovr_cleared", {31'd0, overrun}, 0);

        // Underrun: single sample repeats; clear collides with the next underrun
        repeat (3) exp_q.push_back(16'h7FFF);
        push(16'h7FFF);
        set_en(1'b1);
        for (int k = 1; k <= 1538; k++) begin
            @(posedge sys_clk); #1;
            if (k == 768)  check("udr_before", {31'd0, underrun}, 0);
            if (k == 769)  check("udr_at_frame2", {31'd0, underrun}, 1);
            if (k == 1536) begin
                check("udr_held", {31'd0, underrun}, 1);
                clr_flags = 1'b1;
            end
            if (k == 1537) check("udr_set_wins", {31'd0, underrun}, 1);
            if (k == 1538) begin
                check("udr_cleared", {31'd0, underrun}, 0);
                clr_flags = 1'b0;
                en        = 1'b0;
            end
        end
        wait_idle("udr_idle");
        check("udr_no_overrun", {31'd0, overrun}, 0);
        pulse_clr();

        // Drain: en drops at bit 5, frame completes, remaining entry retained
        exp_q.push_back(16'h1234);
        push(16'h1234);
        push(16'h5678);
        set_en(1'b1);
        repeat (128) @(posedge sys_clk);
        set_en(1'b0);
        check("drain_busy_mid", {31'd0, busy}, 1);
        wait_idle("drain_idle");
        check("drain_outs", {29'd0, dac_bclk, dac_lrclk, dac_sdata}, 0);
        check("drain_no_underrun", {31'd0, underrun}, 0);
        exp_q.push_back(16'h5678);
        set_en(1'b1);
        repeat (10) @(posedge sys_clk);
        set_en(1'b0);
        wait_idle("drain_resume_idle");
        check("drain_resume_flags", {30'd0, overrun, underrun}, 0);

        // Asynchronous reset mid-frame
        push(16'hBEEF);
        set_en(1'b1);
        repeat (200) @(posedge sys_clk);
        #3 reset = 1'b0;
        #1;
        check("arst_outs", {26'd0, dac_bclk, dac_lrclk, dac_sdata, busy, overrun, underrun}, 0);
        exp_q.delete();
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b1;
        repeat (100) @(posedge sys_clk);
        #1;
        check("arst_stays_idle", {30'd0, busy, dac_bclk}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_serializer.md
Name: sample_serializer

Overview:
- Output stage directly downstream of the smoothing filter.
- Accepts one 16-bit filtered sample per sample-rate strobe and buffers it in a small FIFO.
- Serializes each sample MSB-first onto a left-justified stereo DAC link (bit clock, word select, serial data), with the mono sample duplicated on both channels.
- Decouples the filter's strobe timing from the DAC frame timing and flags rate mismatches.

Parameters:
- SAMPLE_W, 16, sample width and bits per channel slot.
- BCLK_DIV, 12, sys_clk cycles per bclk half-period. Frame = 2*SAMPLE_W*2*BCLK_DIV = 768 cycles at defaults.
- FIFO_DEPTH, 2, sample buffer entries (power of two, ≥2).

Ports:
- sys_clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  serializer enable; level-sensitive
- sample_in  in  SAMPLE_W  filtered sample, two's complement
- sample_valid  in  1  single-cycle push strobe; sample_in valid in the same cycle
- clr_flags  in  1  synchronous clear of the sticky flags
- dac_bclk  out  1  bit clock
- dac_lrclk  out  1  word select: 0 = left, 1 = right
- dac_sdata  out  1  serial data
- busy  out  1  high while state ≠ IDLE
- overrun  out  1  sticky: a push was dropped
- underrun  out  1  sticky: a frame started with the FIFO empty

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FIFO emptied, state IDLE, counters 0, frame register 0.
- FIFO:
  - A push with FIFO not full stores sample_in.
  - A push to a full FIFO with no pop in the same cycle drops the sample and sets overrun.
  - Push and pop in the same cycle on a full FIFO: both succeed; no overrun.
  - Push and pop in the same cycle on an empty FIFO: no pop occurs; the push is stored.
- Divider: div_cnt counts 0..BCLK_DIV-1 in RUN/DRAIN. At terminal count it wraps and dac_bclk toggles.
- Falling edge event: dac_bclk 1→0 toggle. Rising edge event: 0→1 toggle.
- bit_cnt (5 bits for the default 32-bit frame) advances on each falling edge event and wraps at 2*SAMPLE_W-1 → 0.
- dac_lrclk = bit_cnt[MSB]. dac_sdata = frame_reg[SAMPLE_W-1 - bit_cnt[low bits]]. Both are registered, so they update in the same cycle as the falling bclk toggle (left-justified format; the DAC samples on the rising edge).
- Frame start is the falling edge event where bit_cnt wraps to 0:
  - FIFO non-empty: pop into frame_reg.
  - FIFO empty: keep frame_reg (repeat the last sample) and set underrun.
- FSM states:
  - IDLE: dac_bclk, dac_lrclk and dac_sdata held 0.
    - If en=1 and FIFO non-empty: pop into frame_reg, bit_cnt=0, div_cnt=0, go to RUN.
    - The first bclk rising toggle occurs BCLK_DIV cycles after entry. dac_sdata presents frame_reg MSB from the cycle after the pop.
  - RUN: serialize continuously. If en=0, go to DRAIN.
  - DRAIN: finish the current frame. At the frame-end falling edge (bit_cnt wrap), go to IDLE without popping, with bclk low. If en returns to 1 during DRAIN, go back to RUN; the frame is not truncated.
- Sticky flags:
  - Cleared by clr_flags.
  - If clr_flags and a set event occur in the same cycle, set wins.
- Reset mid-frame: outputs drop to 0 immediately; no partial-frame recovery.
- No arithmetic on sample data; bits pass through unmodified.

Decomposition:
- Shared package (dsp_pkg):
  - SAMPLE_W default and FRAME_BITS = 2*SAMPLE_W
  - Serializer state enum {IDLE, RUN, DRAIN}
  - Sample type (signed [SAMPLE_W-1:0])
- One sub-module, sample_fifo:
  - Parameterized on depth and width.
  - Ports: push, pop, din, dout, full, empty.
  - Same clock and reset convention.
  - Pointer-based storage, first-word-fall-through.
- The FSM, divider, bit counter and shift select stay in sample_serializer.

Test Plan:
- Basic frame: en=1, push 16'hA5C3. After frame start, sdata over 32 bclk falling edges = A5C3 MSB-first twice. lrclk is 0 for bits 0–15 and 1 for bits 16–31. Frame length is 768 cycles at defaults.
- Steady rate: pushes every 768 cycles with values 1, 2, 3, … Each frame carries consecutive values with none skipped or repeated. overrun=0 and underrun=0 throughout.
- Overrun: push 3 samples (0x1111, 0x2222, 0x3333) within 3 cycles while IDLE with en=0. The third is dropped and overrun=1. After en=1, the frames carry 0x1111 then 0x2222.
- Underrun: push a single 0x7FFF, en=1, no further pushes. The second frame repeats 0x7FFF and underrun rises at the second frame start. clr_flags clears it only after the next underrun event stops occurring (set wins).
- Drain: drop en mid-frame at bit 5. The frame completes all 32 bits, then busy=0 and bclk=0. One remaining FIFO entry is retained and sent after en is re-raised.
- Async reset: assert reset low mid-frame between sys_clk edges. All outputs read 0 before the next clock edge. After release with en=1 and no pushes, the block stays in IDLE.
